sensor_readout_seq: RTL and testbench
=====================================

# sensor_readout_seq

Parametrised successor to the camera control FSM. It sequences one frame: erase, a programmable exposure interval, then a row-by-row readout of `NUM_ROWS` pixel rows, each gated by a handshake with the ADC. It sits between the top-level camera controller, which issues `init`, and the analog pixel array / ADC interface.

## Interface
- `NUM_ROWS`, 2: number of pixel rows read per frame (≥1).
- `EXP_W`, 8: width of the exposure-time input and counter.
- `TIMEOUT_CYC`, 16: ADC handshake timeout in cycles. Only used with `SRS_ADC_TIMEOUT_EN`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `init` in 1: start-of-frame request, sampled in IDLE only.
- `exp_time` in `EXP_W`: exposure length in cycles, latched at frame start. 0 is treated as 1.
- `adc_done` in 1: ADC conversion complete, sampled in CONVERT only.
- `nre` out `NUM_ROWS`: active-low row read enables, at most one bit low at a time.
- `adc_start` out 1: one-cycle pulse that starts a conversion.
- `expose` out 1: pixel exposure active.
- `erase` out 1: pixel erase active.
- `busy` out 1: high whenever the state is not IDLE.
- `frame_done` out 1: one-cycle pulse after the last row converts.
- `adc_err` out 1: sticky timeout flag. Tied 0 without `SRS_ADC_TIMEOUT_EN`.

## Operation
- Moore FSM. All outputs are registered and decoded from the state plus `row_idx`.
- Reset values: `nre` all 1, `adc_start` 0, `expose` 0, `erase` 1, `busy` 0, `frame_done` 0, `adc_err` 0; state IDLE, `row_idx` 0.
- **IDLE:** `erase`=1, all `nre`=1.
  - `init`=1 → EXPOSE.
  - Latch `max(exp_time,1)` into the down-counter.
- **EXPOSE:** `expose`=1, `erase`=0.
  - Counter decrements each cycle.
  - At count==1 → SETTLE with `row_idx`=0.
- **SETTLE:** `nre[row_idx]`=0 for exactly 1 cycle → CONVERT.
  - `adc_start` asserts on the CONVERT entry edge.
- **CONVERT:** `nre[row_idx]`=0; `adc_start` is high for the first cycle only.
  - Wait for `adc_done`=1.
  - If `row_idx`==`NUM_ROWS`-1 → IDLE, with `frame_done` pulsed in the first IDLE cycle.
  - Otherwise → GAP.
- **GAP:** all `nre`=1 for 1 cycle, `row_idx`+1 → SETTLE.
- `row_idx` width is `$clog2(NUM_ROWS)` (min 1). It never wraps within a frame and resets to 0 in IDLE.

Boundary conditions:
- `init` while busy: ignored, not queued.
- `init` held high: a new frame starts on the first IDLE cycle after `frame_done`.
- `adc_done` outside CONVERT: ignored.
- `adc_done` in the same cycle as `adc_start`: accepted; the conversion is 1 cycle.
- `reset` mid-frame: IDLE and reset values on the next edge. No `frame_done`.
- `exp_time` changes during a frame: no effect.

## Timing
- `init` high at edge t → `expose` high from t+1 for E=`max(exp_time,1)` cycles.
- Row r (r ≥ 0) with conversion taking C_r cycles, counting the cycle `adc_done` is seen: `nre[r]` is low for 1+C_r cycles.
- Frame length from `init` edge to `frame_done` cycle: E + Σ(1+C_r) + (NUM_ROWS-1) + 1.
- `busy` rises at t+1 and falls in the `frame_done` cycle.

## Configuration
- **`SRS_ADC_TIMEOUT_EN` defined:**
  - A counter runs in CONVERT.
  - If `adc_done` is not seen within `TIMEOUT_CYC` cycles: set `adc_err` (sticky until `reset`), release `nre`, go to IDLE with no `frame_done`.
- **Undefined:** CONVERT waits indefinitely, `adc_err`=0, and no timeout counter is synthesised.

## Structure
- Shared package `cam_pkg`:
  - state enum `seq_state_t` {IDLE, EXPOSE, SETTLE, CONVERT, GAP};
  - default parameter constants.
- One sub-module, `exp_timer`: a loadable `EXP_W`-bit down-counter with `load`, `value`, and a `last` flag (count==1).

## Test plan
- **Basic frame.** `NUM_ROWS`=2, `exp_time`=3, `adc_done` 2 cycles after each `adc_start`.
  - `expose` is high for 3 cycles; `nre`=2'b10 for 3 cycles; 1 gap cycle; `nre`=2'b01 for 3 cycles.
  - `frame_done` arrives 11 cycles after `init`.
- **Zero exposure.** `exp_time`=0 → `expose` is high for exactly 1 cycle.
- **Immediate ADC.** `adc_done` tied 1 → each row has `nre` low for 2 cycles.
  - `init` pulsed during CONVERT is ignored (exactly one `frame_done`).
- **Reset mid-frame.** `reset` asserted during CONVERT of row 1, `NUM_ROWS`=4.
  - Next cycle: `nre`=4'hF, `erase`=1, `busy`=0, no `frame_done`.
  - A subsequent frame starts at row 0.
- **Timeout.** With `SRS_ADC_TIMEOUT_EN` and `TIMEOUT_CYC`=4, `adc_done` is never asserted.
  - After 4 CONVERT cycles: `adc_err`=1, state IDLE, `frame_done`=0.
  - `adc_err` stays 1 through the next frame until `reset`.

Source files
------------

// File: rtl/cam_pkg.sv
// Shared types and default parameters for the camera readout sequencer.
package cam_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXPOSE  = 3'd1,
        SETTLE  = 3'd2,
        CONVERT = 3'd3,
        GAP     = 3'd4
    } seq_state_t;

    localparam int DEF_NUM_ROWS    = 2;
    localparam int DEF_EXP_W       = 8;
    localparam int DEF_TIMEOUT_CYC = 16;

endpackage

// File: rtl/exp_timer.sv
// Loadable down-counter for the exposure interval; `last` flags count==1.
module exp_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] value,
    output logic         last
);

    logic [W-1:0] value_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            value_q <= '0;
        end else if (load) begin
            value_q <= load_val;
        end else if (dec && value_q != '0) begin
            value_q <= value_q - 1'b1;
        end
    end

    assign value = value_q;
    assign last  = (value_q == W'(1));

endmodule

// File: rtl/sensor_readout_seq.sv
// Frame sequencer: erase, exposure, then row-by-row readout with ADC handshake.
// Optional ADC handshake timeout is enabled by defining SRS_ADC_TIMEOUT_EN.
module sensor_readout_seq
    import cam_pkg::*;
#(
    parameter int NUM_ROWS    = DEF_NUM_ROWS,
    parameter int EXP_W       = DEF_EXP_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic [EXP_W-1:0]    exp_time,
    input  logic                adc_done,
    output logic [NUM_ROWS-1:0] nre,
    output logic                adc_start,
    output logic                expose,
    output logic                erase,
    output logic                busy,
    output logic                frame_done,
    output logic                adc_err
);

    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

    seq_state_t state_q, state_d;
    logic [ROW_W-1:0]    row_q, row_d;
    logic [NUM_ROWS-1:0] nre_q, nre_d;
    logic adc_start_q, expose_q, erase_q, busy_q, frame_done_q;
    logic exp_last, tmo_hit;
    logic [EXP_W-1:0] exp_load;
    logic [EXP_W-1:0] unused_exp_value;

    // Zero exposure is promoted to one cycle so EXPOSE always terminates.
    assign exp_load = (exp_time == '0) ? EXP_W'(1) : exp_time;

    exp_timer #(.W(EXP_W)) u_exp_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == IDLE),
        .load_val (exp_load),
        .dec      (state_q == EXPOSE),
        .value    (unused_exp_value),
        .last     (exp_last)
    );

`ifdef SRS_ADC_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit = (state_q == CONVERT) && !adc_done &&
                     (tmo_q == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= (state_q == CONVERT && !adc_done) ? tmo_q + 1'b1 : '0;
            err_q <= err_q | tmo_hit;
        end
    end

    assign adc_err = err_q;
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = (TIMEOUT_CYC != 0);
    assign tmo_hit        = 1'b0;
    assign adc_err        = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            IDLE:    if (init) state_d = EXPOSE;
            EXPOSE:  if (exp_last) state_d = SETTLE;
            SETTLE:  state_d = CONVERT;
            CONVERT: begin
                if (adc_done) state_d = (row_q == LAST_ROW) ? IDLE : GAP;
                else if (tmo_hit) state_d = IDLE;
            end
            GAP: begin
                state_d = SETTLE;
                row_d   = row_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE || state_d == EXPOSE) row_d = '0;
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        nre_d = '1;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if ((state_d == SETTLE || state_d == CONVERT) && row_d == ROW_W'(i))
                nre_d[i] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            row_q        <= '0;
            nre_q        <= '1;
            adc_start_q  <= 1'b0;
            expose_q     <= 1'b0;
            erase_q      <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            nre_q        <= nre_d;
            adc_start_q  <= (state_q == SETTLE);
            expose_q     <= (state_d == EXPOSE);
            erase_q      <= (state_d == IDLE);
            busy_q       <= (state_d != IDLE);
            frame_done_q <= (state_q == CONVERT) && adc_done && (row_q == LAST_ROW);
        end
    end

    assign nre        = nre_q;
    assign adc_start  = adc_start_q;
    assign expose     = expose_q;
    assign erase      = erase_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_sensor_readout_seq.sv
// Directed bench for sensor_readout_seq: a 2-row and a 4-row instance share stimulus.
module tb_sensor_readout_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       init = 1'b0;
    logic       adc_done = 1'b0;
    logic [7:0] exp_time = 8'd3;

    logic [1:0] nre2;
    logic       adc_start2, expose2, erase2, busy2, fd2, err2;
    logic [3:0] nre4;
    logic       adc_start4, expose4, erase4, busy4, fd4, err4;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sensor_readout_seq #(.NUM_ROWS(2), .EXP_W(8), .TIMEOUT_CYC(4)) dut2 (
        .clk(clk), .reset(reset), .init(init), .exp_time(exp_time), .adc_done(adc_done),
        .nre(nre2), .adc_start(adc_start2), .expose(expose2), .erase(erase2),
        .busy(busy2), .frame_done(fd2), .adc_err(err2)
    );

    sensor_readout_seq #(.NUM_ROWS(4), .EXP_W(8), .TIMEOUT_CYC(4)) dut4 (
        .clk(clk), .reset(reset), .init(init), .exp_time(exp_time), .adc_done(adc_done),
        .nre(nre4), .adc_start(adc_start4), .expose(expose4), .erase(erase4),
        .busy(busy4), .frame_done(fd4), .adc_err(err4)
    );

    // Advance one clock and land on the falling edge, where outputs are sampled.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1; init = 1'b0; adc_done = 1'b0;
        step(); step();
        tests++;
        if ({nre2, adc_start2, expose2, erase2, busy2, fd2, err2} !== 8'b11_0_0_1_0_0_0) begin
            fails++;
            $display("FAIL reset_outs2: got %b want %b",
                     {nre2, adc_start2, expose2, erase2, busy2, fd2, err2}, 8'b11001000);
        end
        tests++;
        if ({nre4, erase4, busy4} !== 6'b1111_1_0) begin
            fails++;
            $display("FAIL reset_outs4: got %b want %b", {nre4, erase4, busy4}, 6'b111110);
        end
        reset = 1'b0;
        step();
        tests++;
        if (busy2 !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy: got %b want 0", busy2);
        end
    endtask

    task automatic test_basic_frame();
        int exp_n = 0, n10 = 0, n01 = 0, gap = 0, st_n = 0, er_n = 0;
        int fd_n = 0, fd_cyc = 0, cc = 0;
        logic exp1 = 1'b0, busy_fd = 1'b1, busy_pre = 1'b0;
        exp_time = 8'd3; init = 1'b1; adc_done = 1'b0;
        step();
        init = 1'b0; exp_time = 8'd200;
        for (int n = 1; n <= 20; n++) begin
            if (n == 1) exp1 = expose2;
            if (n == 10) busy_pre = busy2;
            if (expose2) exp_n++;
            if (nre2 == 2'b10) n10++;
            if (nre2 == 2'b01) n01++;
            if (busy2 && nre2 == 2'b11 && !expose2) gap++;
            if (adc_start2) st_n++;
            if (busy2 && erase2) er_n++;
            if (fd2) begin
                fd_n++;
                if (fd_cyc == 0) begin fd_cyc = n; busy_fd = busy2; end
            end
            if (adc_start2) cc = 1; else if (cc > 0) cc++;
            adc_done = (cc == 2);
            if (cc == 2) cc = 0;
            step();
        end
        adc_done = 1'b0;
        tests++; if (exp1 !== 1'b1) begin fails++; $display("FAIL basic_expose_rise: got %b want 1", exp1); end
        tests++; if (exp_n != 3) begin fails++; $display("FAIL basic_expose_len: got %0d want 3", exp_n); end
        tests++; if (n10 != 3) begin fails++; $display("FAIL basic_row0_len: got %0d want 3", n10); end
        tests++; if (n01 != 3) begin fails++; $display("FAIL basic_row1_len: got %0d want 3", n01); end
        tests++; if (gap != 1) begin fails++; $display("FAIL basic_gap: got %0d want 1", gap); end
        tests++; if (st_n != 2) begin fails++; $display("FAIL basic_adc_start: got %0d want 2", st_n); end
        tests++; if (er_n != 0) begin fails++; $display("FAIL basic_erase_busy: got %0d want 0", er_n); end
        tests++; if (fd_cyc != 11) begin fails++; $display("FAIL basic_fd_cycle: got %0d want 11", fd_cyc); end
        tests++; if (fd_n != 1) begin fails++; $display("FAIL basic_fd_count: got %0d want 1", fd_n); end
        tests++;
        if (busy_pre !== 1'b1 || busy_fd !== 1'b0) begin
            fails++; $display("FAIL basic_busy_fall: got %b%b want 10", busy_pre, busy_fd);
        end
`ifndef SRS_ADC_TIMEOUT_EN
        tests++; if (err2 !== 1'b0) begin fails++; $display("FAIL basic_adc_err: got %b want 0", err2); end
`endif
    endtask

    task automatic test_zero_exposure();
        int exp_n = 0, fd_cyc = 0;
        exp_time = 8'd0; adc_done = 1'b1; init = 1'b1;
        step();
        init = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            if (expose2) exp_n++;
            if (fd2 && fd_cyc == 0) fd_cyc = n;
            step();
        end
        adc_done = 1'b0;
        tests++; if (exp_n != 1) begin fails++; $display("FAIL zero_exp_len: got %0d want 1", exp_n); end
        tests++; if (fd_cyc != 7) begin fails++; $display("FAIL zero_exp_fd: got %0d want 7", fd_cyc); end
    endtask

    task automatic test_immediate_adc();
        int n10 = 0, n01 = 0, busy_n = 0, fd_n = 0, fd_cyc = 0;
        logic pulsed = 1'b0;
        exp_time = 8'd2; adc_done = 1'b1; init = 1'b1;
        step();
        init = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (nre2 == 2'b10) n10++;
            if (nre2 == 2'b01) n01++;
            if (busy2) busy_n++;
            if (fd2) begin fd_n++; if (fd_cyc == 0) fd_cyc = n; end
            if (adc_start2 && !pulsed) begin init = 1'b1; pulsed = 1'b1; end
            else init = 1'b0;
            step();
        end
        adc_done = 1'b0; init = 1'b0;
        tests++; if (n10 != 2) begin fails++; $display("FAIL imm_row0_len: got %0d want 2", n10); end
        tests++; if (n01 != 2) begin fails++; $display("FAIL imm_row1_len: got %0d want 2", n01); end
        tests++; if (fd_n != 1) begin fails++; $display("FAIL imm_init_ignored: got %0d frames want 1", fd_n); end
        tests++; if (fd_cyc != 8) begin fails++; $display("FAIL imm_fd_cycle: got %0d want 8", fd_cyc); end
        tests++; if (busy_n != 7) begin fails++; $display("FAIL imm_busy_len: got %0d want 7", busy_n); end
    endtask

    task automatic test_init_held();
        int fd_n = 0, fd1 = 0, fd2c = 0;
        logic exp8 = 1'b0;
        exp_time = 8'd1; adc_done = 1'b1; init = 1'b1;
        step();
        for (int n = 1; n <= 20; n++) begin
            if (n == 8) exp8 = expose2;
            if (fd2) begin
                fd_n++;
                if (fd1 == 0) fd1 = n; else if (fd2c == 0) fd2c = n;
            end
            init = (n < 8);
            step();
        end
        adc_done = 1'b0; init = 1'b0;
        tests++; if (fd1 != 7) begin fails++; $display("FAIL held_fd1: got %0d want 7", fd1); end
        tests++; if (exp8 !== 1'b1) begin fails++; $display("FAIL held_restart: got %b want 1", exp8); end
        tests++; if (fd2c != 14) begin fails++; $display("FAIL held_fd2: got %0d want 14", fd2c); end
        tests++; if (fd_n != 2) begin fails++; $display("FAIL held_fd_count: got %0d want 2", fd_n); end
    endtask

    task automatic test_reset_mid_frame();
        int fd_seen = 0, fd_cyc = 0, n7 = 0;
        logic [3:0] first_low = 4'hF;
        reset = 1'b1; init = 1'b0; adc_done = 1'b0;
        step();
        reset = 1'b0; exp_time = 8'd1; init = 1'b1;
        step();
        init = 1'b0;
        for (int n = 1; n < 8; n++) begin
            adc_done = (n == 4);
            step();
        end
        adc_done = 1'b0;
        tests++;
        if (nre4 !== 4'hD || busy4 !== 1'b1) begin
            fails++; $display("FAIL rst_pre_row1: got nre=%h busy=%b want D 1", nre4, busy4);
        end
        reset = 1'b1;
        step();
        tests++;
        if ({nre4, erase4, busy4, fd4, expose4, adc_start4} !== 9'b1111_1_0_0_0_0) begin
            fails++; $display("FAIL rst_mid_outs: got %b want %b",
                              {nre4, erase4, busy4, fd4, expose4, adc_start4}, 9'b111110000);
        end
        reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (fd4) fd_seen++;
            step();
        end
        tests++; if (fd_seen != 0) begin fails++; $display("FAIL rst_no_fd: got %0d want 0", fd_seen); end
        exp_time = 8'd1; adc_done = 1'b1; init = 1'b1;
        step();
        init = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            if (first_low == 4'hF && nre4 != 4'hF) first_low = nre4;
            if (nre4 == 4'h7) n7++;
            if (fd4 && fd_cyc == 0) fd_cyc = n;
            step();
        end
        adc_done = 1'b0;
        tests++; if (first_low !== 4'hE) begin fails++; $display("FAIL rst_restart_row0: got %h want E", first_low); end
        tests++; if (n7 != 2) begin fails++; $display("FAIL rows4_last_len: got %0d want 2", n7); end
        tests++; if (fd_cyc != 13) begin fails++; $display("FAIL rows4_fd_cycle: got %0d want 13", fd_cyc); end
    endtask

`ifdef SRS_ADC_TIMEOUT_EN
    task automatic test_timeout();
        logic [1:0] nre_c6 = 2'b11;
        logic       err_c6 = 1'b1;
        int         fd_cyc = 0;
        reset = 1'b1; init = 1'b0; adc_done = 1'b0;
        step();
        reset = 1'b0; exp_time = 8'd1; init = 1'b1;
        step();
        init = 1'b0;
        for (int n = 1; n < 7; n++) begin
            if (n == 6) begin nre_c6 = nre2; err_c6 = err2; end
            step();
        end
        tests++;
        if (nre_c6 !== 2'b10 || err_c6 !== 1'b0) begin
            fails++; $display("FAIL tmo_convert4: got nre=%b err=%b want 10 0", nre_c6, err_c6);
        end
        tests++;
        if ({err2, busy2, fd2, nre2} !== 5'b1_0_0_11) begin
            fails++; $display("FAIL tmo_abort: got %b want 10011", {err2, busy2, fd2, nre2});
        end
        adc_done = 1'b1; init = 1'b1;
        step();
        init = 1'b0;
        for (int n = 1; n <= 10; n++) begin
            if (fd2 && fd_cyc == 0) fd_cyc = n;
            step();
        end
        adc_done = 1'b0;
        tests++; if (fd_cyc != 7) begin fails++; $display("FAIL tmo_next_frame: got %0d want 7", fd_cyc); end
        tests++; if (err2 !== 1'b1) begin fails++; $display("FAIL tmo_sticky: got %b want 1", err2); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests++; if (err2 !== 1'b0) begin fails++; $display("FAIL tmo_clear: got %b want 0", err2); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_frame();
        test_zero_exposure();
        test_immediate_adc();
        test_init_held();
        test_reset_mid_frame();
`ifdef SRS_ADC_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
